uart_rx_ctrl: RTL and testbench

UART receive controller: oversamples the asynchronous serial line, validates the start bit, shifts in 8 data bits LSB-first, optionally checks one parity bit and checks the stop bit. It then presents the received byte with error flags for one cycle. It sits between the top-level RX pin and the FPGA-side consumer. It sequences the shared `parity_checker` datapath, sampling the checker's result only when the parity bit arrives.

---
 rtl/uart_pkg.sv | 18 +
 rtl/uart_rx_ctrl_if.sv | 18 +
 rtl/parity_checker.sv | 9 +
 rtl/uart_rx_ctrl.sv | 120 ++++++++++++
 tb/tb_uart_rx_ctrl.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART receive types and constants
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    PARITY    = 3'd3,
    STOP      = 3'd4,
    WAIT_IDLE = 3'd5
  } uart_state_t;

  localparam logic PARITY_EVEN = 1'b0;
  localparam logic PARITY_ODD  = 1'b1;

  localparam int DEFAULT_CLKS_PER_BIT = 868;

endpackage

// File: rtl/uart_rx_ctrl_if.sv
// rtl/uart_rx_ctrl_if.sv - received-byte result bus from the UART receiver to its consumer
interface uart_rx_ctrl_if;

  logic [7:0] o_data;
  logic       o_valid;
  logic       o_parity_err;
  logic       o_frame_err;
  logic       o_busy;

  modport master (
    output o_data, o_valid, o_parity_err, o_frame_err, o_busy
  );

  modport slave (
    input o_data, o_valid, o_parity_err, o_frame_err, o_busy
  );

endinterface

// File: rtl/parity_checker.sv
// rtl/parity_checker.sv - byte parity datapath; o_parity is high on an even ones-count
module parity_checker (
  input  logic [7:0] i_data,
  output logic       o_parity
);

  assign o_parity = ~(^i_data);

endmodule

// File: rtl/uart_rx_ctrl.sv
// rtl/uart_rx_ctrl.sv - oversampling UART receiver: start validation, 8N/8E/8O framing, error flags
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic           i_clk,
  input  logic           i_rst,
  input  logic           i_rx,
  input  logic           i_parity_en,
  input  logic           i_parity_odd,
  uart_rx_ctrl_if.master rx_bus
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);

  uart_state_t   r_state;
  uart_state_t   w_next;
  logic          r_rx_meta;
  logic          r_rx;
  logic [1:0]    r_flush;
  logic          r_armed;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_idx;
  logic [7:0]    r_shift;
  logic          r_par_en;
  logic          r_par_odd;
  logic          r_par_err;
  logic [7:0]    r_data;
  logic          r_valid;
  logic          r_out_perr;
  logic          r_out_ferr;
  logic          w_even;
  logic          w_full;
  logic          w_half;
  logic          w_start;

  parity_checker u_parity_checker (
    .i_data   (r_shift),
    .o_parity (w_even)
  );

  assign w_full  = (r_cnt == FULL_M1);
  assign w_half  = (r_cnt == HALF_M1);
  // Start detection waits until the line has been seen high once the synchronizer has flushed,
  // so a line that is already low when reset releases is not mistaken for a start bit.
  assign w_start = r_armed & ~r_rx;

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:      if (w_start) w_next = START;
      START:     if (w_half) w_next = r_rx ? IDLE : DATA;
      DATA:      if (w_full && r_idx == 3'd7) w_next = r_par_en ? PARITY : STOP;
      PARITY:    if (w_full) w_next = STOP;
      STOP:      if (w_full) w_next = r_rx ? IDLE : WAIT_IDLE;
      WAIT_IDLE: if (r_rx) w_next = IDLE;
      default:   w_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= IDLE;
      r_rx_meta  <= 1'b1;
      r_rx       <= 1'b1;
      r_flush    <= 2'b00;
      r_armed    <= 1'b0;
      r_cnt      <= '0;
      r_idx      <= 3'd0;
      r_shift    <= 8'h00;
      r_par_en   <= 1'b0;
      r_par_odd  <= PARITY_EVEN;
      r_par_err  <= 1'b0;
      r_data     <= 8'h00;
      r_valid    <= 1'b0;
      r_out_perr <= 1'b0;
      r_out_ferr <= 1'b0;
    end else begin
      r_rx_meta <= i_rx;
      r_rx      <= r_rx_meta;
      r_flush   <= {r_flush[0], 1'b1};
      r_armed   <= r_armed | (r_flush[1] & r_rx);
      r_state   <= w_next;
      r_cnt     <= (w_next != r_state || w_full) ? '0 : r_cnt + 1'b1;
      r_valid   <= 1'b0;
      case (r_state)
        IDLE: if (w_start) begin
          r_par_en  <= i_parity_en;
          r_par_odd <= i_parity_odd;
          r_par_err <= 1'b0;
          r_idx     <= 3'd0;
        end
        DATA: if (w_full) begin
          r_shift[r_idx] <= r_rx;
          r_idx          <= r_idx + 3'd1;
        end
        PARITY: if (w_full) begin
          r_par_err <= r_rx ^ ((r_par_odd == PARITY_ODD) ? w_even : ~w_even);
        end
        STOP: if (w_full) begin
          r_valid    <= 1'b1;
          r_data     <= r_shift;
          r_out_perr <= r_par_err;
          r_out_ferr <= ~r_rx;
        end
        default: ;
      endcase
    end
  end

  assign rx_bus.o_data       = r_data;
  assign rx_bus.o_valid      = r_valid;
  assign rx_bus.o_parity_err = r_out_perr;
  assign rx_bus.o_frame_err  = r_out_ferr;
  assign rx_bus.o_busy       = (r_state != IDLE);

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb/tb_uart_rx_ctrl.sv - directed self-checking bench for uart_rx_ctrl at 8 clocks per bit
module tb_uart_rx_ctrl;
  import uart_pkg::*;

  localparam int C      = 8;
  localparam int LAT_NP = 2 + 1 + C/2 + 9*C + 1;
  localparam int LAT_P  = 2 + 1 + C/2 + 10*C + 1;

  logic clk = 1'b0;
  logic rst, rx, pen, podd;

  uart_rx_ctrl_if bus ();

  uart_rx_ctrl #(.CLKS_PER_BIT(C)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_rx         (rx),
    .i_parity_en  (pen),
    .i_parity_odd (podd),
    .rx_bus       (bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int vcnt   = 0;
  int vcyc   = 0;
  int dbl    = 0;
  logic [7:0] cap_data = 8'h00;
  logic cap_perr = 1'b0;
  logic cap_ferr = 1'b0;
  logic prev_v   = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.o_valid === 1'b1) begin
      vcnt++;
      vcyc     = cyc;
      cap_data = bus.o_data;
      cap_perr = bus.o_parity_err;
      cap_ferr = bus.o_frame_err;
      if (prev_v) dbl++;
    end
    prev_v = bus.o_valid;
  end

  task automatic bit_time(input logic b);
    rx = b;
    repeat (C) @(negedge clk);
  endtask

  task automatic xfer(input logic [7:0] d, input bit par, input bit pbit, input bit stop,
                      output int got, output int lat);
    int n0, t0, k;
    n0 = vcnt;
    t0 = cyc;
    bit_time(1'b0);
    for (int i = 0; i < 8; i++) bit_time(d[i]);
    if (par) bit_time(pbit);
    bit_time(stop);
    k = 0;
    while (vcnt == n0 && k < 4*C) begin
      @(negedge clk);
      k++;
    end
    got = vcnt - n0;
    lat = (got > 0) ? vcyc - t0 : -1;
  endtask

  task automatic test_reset();
    rst = 1'b1; rx = 1'b1; pen = 1'b0; podd = PARITY_EVEN;
    repeat (3) @(negedge clk);
    checks++; if (bus.o_data !== 8'h00) begin errors++; $display("FAIL reset_data: got %h want 00", bus.o_data); end
    checks++; if (bus.o_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", bus.o_valid); end
    checks++; if (bus.o_parity_err !== 1'b0) begin errors++; $display("FAIL reset_perr: got %b want 0", bus.o_parity_err); end
    checks++; if (bus.o_frame_err !== 1'b0) begin errors++; $display("FAIL reset_ferr: got %b want 0", bus.o_frame_err); end
    checks++; if (bus.o_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", bus.o_busy); end
    rst = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_no_parity();
    int got, lat;
    pen = 1'b0;
    xfer(8'hA5, 1'b0, 1'b0, 1'b1, got, lat);
    checks++; if (got !== 1) begin errors++; $display("FAIL np_count: got %0d want 1", got); end
    checks++; if (cap_data !== 8'hA5) begin errors++; $display("FAIL np_data: got %h want a5", cap_data); end
    checks++; if (cap_perr !== 1'b0) begin errors++; $display("FAIL np_perr: got %b want 0", cap_perr); end
    checks++; if (cap_ferr !== 1'b0) begin errors++; $display("FAIL np_ferr: got %b want 0", cap_ferr); end
    checks++; if (lat < LAT_NP - 1 || lat > LAT_NP + 1) begin errors++; $display("FAIL np_latency: got %0d want %0d+-1", lat, LAT_NP); end
    checks++; if (bus.o_busy !== 1'b0) begin errors++; $display("FAIL np_idle_busy: got %b want 0", bus.o_busy); end
  endtask

  task automatic test_even_parity();
    int got, lat;
    pen = 1'b1; podd = PARITY_EVEN;
    xfer(8'h07, 1'b1, 1'b1, 1'b1, got, lat);
    checks++; if (got !== 1) begin errors++; $display("FAIL even_ok_count: got %0d want 1", got); end
    checks++; if (cap_perr !== 1'b0) begin errors++; $display("FAIL even_ok_perr: got %b want 0", cap_perr); end
    checks++; if (lat < LAT_P - 1 || lat > LAT_P + 1) begin errors++; $display("FAIL even_latency: got %0d want %0d+-1", lat, LAT_P); end
    xfer(8'h07, 1'b1, 1'b0, 1'b1, got, lat);
    checks++; if (got !== 1) begin errors++; $display("FAIL even_bad_count: got %0d want 1", got); end
    checks++; if (cap_perr !== 1'b1) begin errors++; $display("FAIL even_bad_perr: got %b want 1", cap_perr); end
    checks++; if (cap_data !== 8'h07) begin errors++; $display("FAIL even_bad_data: got %h want 07", cap_data); end
  endtask

  task automatic test_odd_parity();
    int got, lat;
    pen = 1'b1; podd = PARITY_ODD;
    xfer(8'h03, 1'b1, 1'b1, 1'b1, got, lat);
    checks++; if (got !== 1) begin errors++; $display("FAIL odd_ok_count: got %0d want 1", got); end
    checks++; if (cap_perr !== 1'b0) begin errors++; $display("FAIL odd_ok_perr: got %b want 0", cap_perr); end
    checks++; if (cap_data !== 8'h03) begin errors++; $display("FAIL odd_ok_data: got %h want 03", cap_data); end
    xfer(8'h00, 1'b1, 1'b0, 1'b1, got, lat);
    checks++; if (got !== 1) begin errors++; $display("FAIL odd_bad_count: got %0d want 1", got); end
    checks++; if (cap_perr !== 1'b1) begin errors++; $display("FAIL odd_bad_perr: got %b want 1", cap_perr); end
    checks++; if (cap_data !== 8'h00) begin errors++; $display("FAIL odd_bad_data: got %h want 00", cap_data); end
    pen = 1'b0; podd = PARITY_EVEN;
  endtask

  task automatic test_glitch();
    int n0;
    logic busy_seen;
    n0 = vcnt;
    busy_seen = 1'b0;
    rx = 1'b0;
    repeat (3) @(negedge clk);
    rx = 1'b1;
    for (int i = 0; i < 3*C; i++) begin
      @(negedge clk);
      if (bus.o_busy === 1'b1) busy_seen = 1'b1;
    end
    checks++; if (busy_seen !== 1'b1) begin errors++; $display("FAIL glitch_busy_rise: got %b want 1", busy_seen); end
    checks++; if (bus.o_busy !== 1'b0) begin errors++; $display("FAIL glitch_busy_drop: got %b want 0", bus.o_busy); end
    checks++; if (vcnt !== n0) begin errors++; $display("FAIL glitch_no_valid: got %0d want %0d", vcnt, n0); end
  endtask

  task automatic test_break();
    int got, lat, n1;
    pen = 1'b0;
    xfer(8'h3C, 1'b0, 1'b0, 1'b0, got, lat);
    n1 = vcnt;
    repeat (40) @(negedge clk);
    checks++; if (got !== 1) begin errors++; $display("FAIL brk_count: got %0d want 1", got); end
    checks++; if (cap_data !== 8'h3C) begin errors++; $display("FAIL brk_data: got %h want 3c", cap_data); end
    checks++; if (cap_ferr !== 1'b1) begin errors++; $display("FAIL brk_ferr: got %b want 1", cap_ferr); end
    checks++; if (cap_perr !== 1'b0) begin errors++; $display("FAIL brk_perr: got %b want 0", cap_perr); end
    checks++; if (bus.o_busy !== 1'b1) begin errors++; $display("FAIL brk_wait_busy: got %b want 1", bus.o_busy); end
    checks++; if (vcnt !== n1) begin errors++; $display("FAIL brk_extra_valid: got %0d want %0d", vcnt, n1); end
    rx = 1'b1;
    repeat (5) @(negedge clk);
    checks++; if (bus.o_busy !== 1'b0) begin errors++; $display("FAIL brk_release_busy: got %b want 0", bus.o_busy); end
  endtask

  task automatic test_back_to_back();
    int got, lat, n0;
    logic [7:0] first;
    n0 = vcnt;
    pen = 1'b0;
    xfer(8'h55, 1'b0, 1'b0, 1'b1, got, lat);
    first = cap_data;
    xfer(8'hAA, 1'b0, 1'b0, 1'b1, got, lat);
    checks++; if (first !== 8'h55) begin errors++; $display("FAIL b2b_first: got %h want 55", first); end
    checks++; if (cap_data !== 8'hAA) begin errors++; $display("FAIL b2b_second: got %h want aa", cap_data); end
    checks++; if (vcnt !== n0 + 2) begin errors++; $display("FAIL b2b_count: got %0d want %0d", vcnt - n0, 2); end
    // third frame 0xFC: start bit and two low data bits, reset lands inside bit 1
    bit_time(1'b0);
    bit_time(1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++; if (bus.o_busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", bus.o_busy); end
    checks++; if (bus.o_data !== 8'h00) begin errors++; $display("FAIL rst_data: got %h want 00", bus.o_data); end
    checks++; if (bus.o_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b want 0", bus.o_valid); end
    checks++; if (bus.o_frame_err !== 1'b0 || bus.o_parity_err !== 1'b0) begin errors++; $display("FAIL rst_flags: got %b%b want 00", bus.o_frame_err, bus.o_parity_err); end
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    rx = 1'b1;
    repeat (12*C) @(negedge clk);
    checks++; if (vcnt !== n0 + 2) begin errors++; $display("FAIL rst_no_valid: got %0d want %0d", vcnt - n0, 2); end
    checks++; if (bus.o_busy !== 1'b0) begin errors++; $display("FAIL rst_idle: got %b want 0", bus.o_busy); end
    checks++; if (dbl !== 0) begin errors++; $display("FAIL valid_double: got %0d want 0", dbl); end
  endtask

  initial begin
    rst = 1'b1; rx = 1'b1; pen = 1'b0; podd = 1'b0;
    @(negedge clk);
    test_reset();
    test_no_parity();
    test_even_parity();
    test_odd_parity();
    test_glitch();
    test_break();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
